mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide/modulo sequencer for the EX stage of the pipelined processor. It accepts a `mul`, `div` or `mod` instruction that the decoder has flagged, and runs an iterative shift-add or restoring-divide datapath over several cycles. While it runs, it stalls the upstream pipeline. When it finishes, it presents a single-cycle result to the EX/MEM latch.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_iter_step.sv | 35 +++
 rtl/mdu_sequencer.sv | 153 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide/modulo sequencer.
package mdu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ABS_W    = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } mdu_state_t;

    typedef enum logic [1:0] {
        OP_MUL,
        OP_DIV,
        OP_MOD
    } mdu_op_t;

    // Conditional two's-complement negate on a wide value; callers zero-extend
    // their operand and truncate the result, so it works for any XLEN <= ABS_W.
    function automatic logic [ABS_W-1:0] mdu_abs(input logic [ABS_W-1:0] value,
                                                 input logic             neg);
        return neg ? (~value + ABS_W'(1)) : value;
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the sequencer datapath: MSB-first shift-add multiply or
// one restoring-division step. Purely combinational.
module mdu_iter_step
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] opnd,
    input  mdu_op_t         op,
    output logic [XLEN-1:0] acc_next,
    output logic [XLEN-1:0] rem_next
);

    logic [XLEN:0] shifted;
    logic          fits;

    always_comb begin
        acc_next = acc;
        rem_next = rem;
        shifted  = {rem, acc[XLEN-1]};
        fits     = (shifted >= {1'b0, opnd});
        if (op == OP_MUL) begin
            // rem holds the multiplier; its MSB selects whether to add this cycle
            acc_next = (acc << 1) + (rem[XLEN-1] ? opnd : '0);
            rem_next = rem << 1;
        end else begin
            // acc shifts the dividend out and the quotient bits in
            acc_next = {acc[XLEN-2:0], fits};
            rem_next = fits ? (shifted[XLEN-1:0] - opnd) : shifted[XLEN-1:0];
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle mul/div/mod sequencer for the EX stage, stalling the pipeline
// while it iterates. Define MDU_FAST_MUL_EN for a single-cycle multiplier.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            is_mul,
    input  logic            is_div,
    input  logic            is_mod,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall_o,
    output logic            busy,
    output logic            res_valid,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    mdu_state_t      state, state_next;
    mdu_op_t         op_in, op_q;
    logic            start, b_zero, sign_in, sign_q, short_path;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] acc_q, rem_q, opnd_q;
    logic [XLEN-1:0] acc_step, rem_step;
    logic [XLEN-1:0] fix_sel, fix_val;

    assign start  = ex_valid & (is_mul | is_div | is_mod) & ~flush;
    assign b_zero = (op_b == '0);
    assign a_mag  = XLEN'(mdu_abs(ABS_W'(op_a), op_a[XLEN-1]));
    assign b_mag  = XLEN'(mdu_abs(ABS_W'(op_b), op_b[XLEN-1]));

    always_comb begin
        op_in = OP_MOD;
        if (is_mul) begin
            op_in = OP_MUL;
        end else if (is_div) begin
            op_in = OP_DIV;
        end
    end

    // A zero divisor keeps the division sign clear so div/0 stays all-ones.
    always_comb begin
        sign_in = op_a[XLEN-1] ^ op_b[XLEN-1];
        if (op_in == OP_MOD) begin
            sign_in = op_a[XLEN-1];
        end else if (op_in == OP_DIV) begin
            sign_in = (op_a[XLEN-1] ^ op_b[XLEN-1]) & ~b_zero;
        end
    end

    assign short_path = (op_in == OP_MUL) ? FAST_MUL : b_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = short_path ? FIX : CALC;
            CALC: if (cnt == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        stall_o = rst_n & ~flush & (((state == IDLE) & start) | (state == CALC) | (state == FIX));
        busy    = (state != IDLE);
    end

    mdu_iter_step #(
        .XLEN(XLEN)
    ) u_step (
        .acc     (acc_q),
        .rem     (rem_q),
        .opnd    (opnd_q),
        .op      (op_q),
        .acc_next(acc_step),
        .rem_next(rem_step)
    );

    assign fix_sel = (op_q == OP_MOD) ? rem_q : acc_q;
    assign fix_val = XLEN'(mdu_abs(ABS_W'(fix_sel), sign_q));

    // Control and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_MUL;
            sign_q    <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= (state == FIX) & ~flush;
            if (state == IDLE && start) begin
                op_q   <= op_in;
                sign_q <= sign_in;
                cnt    <= CNT_W'(XLEN - 1);
            end else if (state == CALC) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == FIX && !flush) begin
                result <= fix_val;
            end
        end
    end

    // Datapath registers: magnitudes on accept, one step per CALC cycle
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            opnd_q <= (op_in == OP_MUL) ? a_mag : b_mag;
            if (op_in == OP_MUL) begin
`ifdef MDU_FAST_MUL_EN
                acc_q <= a_mag * b_mag;
`else
                acc_q <= '0;
`endif
                rem_q <= b_mag;
            end else if (b_zero) begin
                acc_q <= '1;
                rem_q <= a_mag;
            end else begin
                acc_q <= a_mag;
                rem_q <= '0;
            end
        end else if (state == CALC) begin
            acc_q <= acc_step;
            rem_q <= rem_step;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table, random ops against a
// reference model, plus flush and mid-operation reset sequences.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        is_mul = 1'b0;
    logic        is_div = 1'b0;
    logic        is_mod = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall_o;
    logic        busy;
    logic        res_valid;
    logic [31:0] result;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_ST = 2;
`else
    localparam int MUL_ST = 34;
`endif

    mdu_sequencer #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .is_mul   (is_mul),
        .is_div   (is_div),
        .is_mod   (is_mod),
        .op_a     (op_a),
        .op_b     (op_b),
        .flush    (flush),
        .stall_o  (stall_o),
        .busy     (busy),
        .res_valid(res_valid),
        .result   (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ops;     // {mod, div, mul}
        logic [31:0] exp;
        int          stalls;
        string       name;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] ops);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        if (ops[0]) begin
            r = a * b;
        end else if (ops[1]) begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = sa / sb;
        end else begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = sa % sb;
        end
        return r;
    endfunction

    // Called just after a rising edge; returns just after the edge that leaves DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ops,
                          input logic [31:0] exp, input int exp_st, input string name);
        int          stalls;
        bit          got;
        logic [31:0] want;
        ex_valid = 1'b1;
        is_mul   = ops[0];
        is_div   = ops[1];
        is_mod   = ops[2];
        op_a     = a;
        op_b     = b;
        exp_q.push_back(exp);
        stalls = 0;
        got    = 1'b0;
        @(negedge clk);
        check({name, "_accept"}, {29'd0, busy, stall_o, res_valid}, 32'b010);
        if (stall_o) stalls++;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            if (stall_o) stalls++;
        end
        want = exp_q.pop_front();
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: no res_valid within 100 cycles, expected result %h", name, want);
        end else begin
            check({name, "_result"}, result, want);
        end
        check({name, "_stalls"}, 32'(stalls), 32'(exp_st));
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        is_mod   = 1'b0;
    endtask

    initial begin
        bit rv_seen;
        vecs[0]  = '{32'd7,        32'hFFFF_FFFA, 3'b001, 32'hFFFF_FFD6, MUL_ST, "mul_7_m6"};
        vecs[1]  = '{32'hFFFF_FF9C, 32'd7,        3'b010, 32'hFFFF_FFF2, 34,     "div_m100_7"};
        vecs[2]  = '{32'hFFFF_FF9C, 32'd7,        3'b100, 32'hFFFF_FFFE, 34,     "mod_m100_7"};
        vecs[3]  = '{32'd5,        32'd0,        3'b010, 32'hFFFF_FFFF, 2,      "div_5_0"};
        vecs[4]  = '{32'd5,        32'd0,        3'b100, 32'd5,        2,      "mod_5_0"};
        vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b010, 32'h8000_0000, 34,    "div_min_m1"};
        vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 32'd0,        34,     "mod_min_m1"};
        vecs[7]  = '{32'd3,        32'd4,        3'b001, 32'd12,       MUL_ST, "mul_3_4"};
        vecs[8]  = '{32'd100,      32'hFFFF_FFF9, 3'b010, 32'hFFFF_FFF2, 34,     "div_100_m7"};
        vecs[9]  = '{32'd100,      32'hFFFF_FFF9, 3'b100, 32'd2,        34,     "mod_100_m7"};
        vecs[10] = '{32'hFFFF_FFFD, 32'd5,        3'b111, 32'hFFFF_FFF1, MUL_ST, "prio_mul"};
        vecs[11] = '{32'd20,       32'd6,        3'b110, 32'd3,        34,     "prio_div"};
        vecs[12] = '{32'h0001_0000, 32'h0001_0000, 3'b001, 32'd0,        MUL_ST, "mul_wrap"};
        vecs[13] = '{32'hFFFF_FFFB, 32'd0,        3'b100, 32'hFFFF_FFFB, 2,      "mod_m5_0"};

        #12;
        check("reset_outputs", {busy, stall_o, res_valid}, 3'b000);
        check("reset_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vectors run back-to-back: each new op appears the cycle after DONE.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ops, vecs[i].exp, vecs[i].stalls, vecs[i].name);
        end

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [2:0]  ops;
            int          bi;
            a   = $urandom;
            bi  = int'($urandom_range(0, 40)) - 20;
            b   = (i % 2 == 0) ? $urandom : 32'(bi);
            ops = 3'b001 << $urandom_range(0, 2);
            run_op(a, b, ops, model(a, b, ops),
                   ops[0] ? MUL_ST : ((b == 0) ? 2 : 34), $sformatf("rand%0d", i));
        end

        // Flush in the tenth CALC cycle
        ex_valid = 1'b1;
        is_div   = 1'b1;
        op_a     = 32'd1000;
        op_b     = 32'd3;
        @(negedge clk);
        check("flush_accept_stall", {31'd0, stall_o}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        ex_valid = 1'b0;
        is_div   = 1'b0;
        @(negedge clk);
        check("flush_idle", {30'd0, busy, stall_o}, 32'd0);
        rv_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) rv_seen = 1'b1;
        end
        check("flush_no_res_valid", {31'd0, rv_seen}, 32'd0);

        // Asynchronous reset in the middle of CALC
        @(posedge clk);
        #1;
        ex_valid = 1'b1;
        is_mul   = 1'b1;
        op_a     = 32'd7;
        op_b     = 32'd9;
        repeat (6) @(posedge clk);
        #3;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {busy, stall_o, res_valid}, 3'b000);
        check("async_reset_result", result, 32'd0);
        ex_valid = 1'b0;
        is_mul   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(32'd7, 32'hFFFF_FFFA, 3'b001, 32'hFFFF_FFD6, MUL_ST, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
